// File: rtl/spi_reg_bank.sv
// SPI register receiver: mode-0 frames of {addr, data} land in shadow registers
// and reach o_regs on a commit strobe (or directly when IMMEDIATE is set).
module spi_reg_bank #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IMMEDIATE   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_sclk,
  input  logic                       i_mosi,
  input  logic                       i_ss_n,
  input  logic                       i_commit,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic                       o_pending,
  output logic                       o_wr_valid,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic                       o_frame_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   bit_stb, ss_fall, ss_rise;

  logic                   armed;
  logic                   eof_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_W-1:0]     shift_q;
  logic [ADDR_W-1:0]      frame_addr;
  logic [DATA_W-1:0]      frame_data;
  logic                   accept_c, reject_c, commit_c;

  logic [NUM_REGS*DATA_W-1:0] shadow_q;
  logic [NUM_REGS-1:0]        dirty_q;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign bit_stb = armed & ~ss_s & sclk_s & ~sclk_d;
  assign ss_fall = ~ss_s & ss_d;
  assign ss_rise = ss_s & ~ss_d;

  assign frame_addr = shift_q[FRAME_W-1 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign commit_c   = i_commit && (IMMEDIATE == 0);

  // Input synchronisers plus one extra copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // Bit counter, shifter and arming; eof_q marks the cycle after a select release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      eof_q   <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      armed <= armed | ss_s;
      eof_q <= armed & ss_rise;
      if (ss_fall) begin
        cnt_q <= '0;
      end else if (bit_stb && cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (bit_stb) begin
        shift_q <= {shift_q[FRAME_W-2:0], mosi_s};
      end
    end
  end

  // Frame verdict; an empty frame is dropped without comment
  always_comb begin
    accept_c = 1'b0;
    reject_c = 1'b0;
    if (eof_q && cnt_q != '0) begin
      if (cnt_q == CNT_FULL && {1'b0, frame_addr} < REG_LIMIT) begin
        accept_c = 1'b1;
      end else begin
        reject_c = 1'b1;
      end
    end
  end

  // Commit copies pre-edge shadow values; a same-edge write stays dirty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      dirty_q     <= '0;
      o_regs      <= '0;
      o_pending   <= 1'b0;
      o_wr_valid  <= 1'b0;
      o_wr_addr   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_wr_valid  <= accept_c;
      o_frame_err <= reject_c;
      o_pending   <= |dirty_q;
      if (accept_c) begin
        o_wr_addr <= frame_addr;
      end
      if (commit_c) begin
        dirty_q <= '0;
      end
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (commit_c && dirty_q[k]) begin
          o_regs[k*DATA_W +: DATA_W] <= shadow_q[k*DATA_W +: DATA_W];
        end
        if (accept_c && frame_addr == ADDR_W'(k)) begin
          if (IMMEDIATE != 0) begin
            o_regs[k*DATA_W +: DATA_W] <= frame_data;
          end else begin
            shadow_q[k*DATA_W +: DATA_W] <= frame_data;
            dirty_q[k]                   <= 1'b1;
          end
        end
      end
    end
  end

endmodule
